bus_arbiter: RTL and testbench

Shares the single CPU main bus (read_addr/read_data, write_addr/write_data/write_strobe) between several bus masters: the core plus a boot loader/DMA engine. It arbitrates cycle by cycle using round-robin priority, and supports bounded bus locking for atomic sequences. It returns read data to the issuing master after the fixed RAM read latency. It sits between the masters and the shared ram/gpio slaves inside cpu.

---
 rtl/bus_pkg.sv | 16 +
 rtl/rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared defaults and master identifiers for the CPU main-bus arbiter.
// Modules that take these as parameters may override them per instance.
package bus_pkg;

    localparam int N_MASTERS    = 2;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int READ_LATENCY = 1;
    localparam int LOCK_MAX     = 16;

    typedef logic [$clog2(N_MASTERS)-1:0] master_id_t;

    localparam master_id_t MASTER_CORE   = master_id_t'(0);
    localparam master_id_t MASTER_LOADER = master_id_t'(1);

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first requester at or after
// 'start' (wrapping) wins, returned both one-hot and encoded.
module rr_pick #(
    parameter int N_MASTERS = 2,
    parameter int ID_W      = 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [ID_W-1:0]      start,
    output logic [N_MASTERS-1:0] gnt,
    output logic [ID_W-1:0]      id,
    output logic                 valid
);
    import bus_pkg::*;

    logic [ID_W-1:0] idx_s;
    logic            hit_s;

    // Walk the requesters in rotated order and keep only the first hit.
    always_comb begin
        gnt   = '0;
        id    = '0;
        valid = 1'b0;
        idx_s = '0;
        hit_s = 1'b0;
        for (int off = 0; off < N_MASTERS; off++) begin
            idx_s      = ID_W'((int'(start) + off) % N_MASTERS);
            hit_s      = req[idx_s] & ~valid;
            gnt[idx_s] = hit_s;
            id         = hit_s ? idx_s : id;
            valid      = valid | hit_s;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the CPU main bus between the core and the
// loader/DMA engine, with bounded bus locking and read-data return routing.
module bus_arbiter #(
    parameter int N_MASTERS    = 2,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int LOCK_MAX     = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [N_MASTERS-1:0]        m_req,
    input  logic [N_MASTERS-1:0]        m_we,
    input  logic [N_MASTERS-1:0]        m_lock,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0]        m_gnt,
    output logic [N_MASTERS-1:0]        m_rvalid,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [ADDR_W-1:0]           read_addr,
    input  logic [DATA_W-1:0]           read_data,
    output logic [ADDR_W-1:0]           write_addr,
    output logic [DATA_W-1:0]           write_data,
    output logic                        write_strobe
);
    import bus_pkg::*;

    localparam int ID_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef logic [ID_W-1:0] id_t;
    typedef struct packed {
        logic valid;
        id_t  id;
    } rd_tag_t;

    id_t                  last_gnt_r;
    logic                 owner_vld_r;
    id_t                  owner_id_r;
    logic [CNT_W-1:0]     lock_cnt_r;
    rd_tag_t              rd_pipe_r [READ_LATENCY];
    logic [ADDR_W-1:0]    rd_addr_r;
    logic [ADDR_W-1:0]    wr_addr_r;
    logic [DATA_W-1:0]    wr_data_r;

    id_t                  start_s;
    logic [N_MASTERS-1:0] pick_gnt_s;
    id_t                  pick_id_s;
    logic                 pick_vld_s;
    logic [N_MASTERS-1:0] gnt_s;
    id_t                  gnt_id_s;
    logic                 gnt_vld_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic                 wr_go_s;
    logic                 rd_go_s;

    assign start_s = (last_gnt_r == id_t'(N_MASTERS - 1)) ? '0 : last_gnt_r + id_t'(1);

    rr_pick #(
        .N_MASTERS (N_MASTERS),
        .ID_W      (ID_W)
    ) u_rr_pick (
        .req   (m_req),
        .start (start_s),
        .gnt   (pick_gnt_s),
        .id    (pick_id_s),
        .valid (pick_vld_s)
    );

    // Grant selection: reset suppresses, a lock owner excludes everyone else.
    always_comb begin
        gnt_s     = '0;
        gnt_id_s  = '0;
        gnt_vld_s = 1'b0;
        if (i_reset) begin
            gnt_vld_s = 1'b0;
        end else if (owner_vld_r) begin
            gnt_vld_s             = m_req[owner_id_r];
            gnt_id_s              = owner_id_r;
            gnt_s[owner_id_r]     = m_req[owner_id_r];
        end else begin
            gnt_vld_s = pick_vld_s;
            gnt_id_s  = pick_id_s;
            gnt_s     = pick_gnt_s;
        end
    end

    assign sel_addr_s   = m_addr[int'(gnt_id_s)*ADDR_W +: ADDR_W];
    assign sel_data_s   = m_wdata[int'(gnt_id_s)*DATA_W +: DATA_W];
    assign wr_go_s      = gnt_vld_s & m_we[gnt_id_s];
    assign rd_go_s      = gnt_vld_s & ~m_we[gnt_id_s];

    assign m_gnt        = gnt_s;
    assign write_strobe = wr_go_s;
    assign write_addr   = wr_go_s ? sel_addr_s : wr_addr_r;
    assign write_data   = wr_go_s ? sel_data_s : wr_data_r;
    assign read_addr    = rd_go_s ? sel_addr_s : rd_addr_r;
    assign m_rdata      = read_data;

    // Arbitration history, lock ownership and bus holding values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_gnt_r  <= id_t'(N_MASTERS - 1);
            owner_vld_r <= 1'b0;
            owner_id_r  <= '0;
            lock_cnt_r  <= '0;
            rd_addr_r   <= '0;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
        end else begin
            if (gnt_vld_s) begin
                last_gnt_r <= gnt_id_s;
            end
            if (wr_go_s) begin
                wr_addr_r <= sel_addr_s;
                wr_data_r <= sel_data_s;
            end
            if (rd_go_s) begin
                rd_addr_r <= sel_addr_s;
            end
            // The owner is always granted when it requests, so a dropped
            // m_lock ends ownership whether or not it was granted this cycle.
            if (owner_vld_r) begin
                if (lock_cnt_r == CNT_W'(LOCK_MAX - 1)) begin
                    owner_vld_r <= 1'b0;
                    lock_cnt_r  <= '0;
                end else if (!m_lock[owner_id_r]) begin
                    owner_vld_r <= 1'b0;
                    lock_cnt_r  <= '0;
                end else begin
                    lock_cnt_r  <= lock_cnt_r + CNT_W'(1);
                end
            end else if (gnt_vld_s && m_lock[gnt_id_s]) begin
                owner_vld_r <= 1'b1;
                owner_id_r  <= gnt_id_s;
                lock_cnt_r  <= '0;
            end
        end
    end

    // Read-return tag pipeline, one stage per cycle of slave latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_pipe_r[k] <= '0;
            end
        end else begin
            rd_pipe_r[0] <= '{valid: rd_go_s, id: gnt_id_s};
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_pipe_r[k] <= rd_pipe_r[k-1];
            end
        end
    end

    // Return strobe; a read in flight when reset arrives never reports.
    always_comb begin
        m_rvalid = '0;
        if (rd_pipe_r[READ_LATENCY-1].valid && !i_reset) begin
            m_rvalid[rd_pipe_r[READ_LATENCY-1].id] = 1'b1;
        end else begin
            m_rvalid = '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed stimulus, a behavioural bus model checked
// every cycle, and literal expectations for the scenarios of interest.
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 1;
    localparam int LM = 4;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [N-1:0]    m_req, m_we, m_lock;
    logic [AW-1:0]   a0, a1;
    logic [DW-1:0]   d0, d1;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_gnt, m_rvalid;
    logic [DW-1:0]   m_rdata, read_data, write_data;
    logic [AW-1:0]   read_addr, write_addr;
    logic            write_strobe;

    assign m_addr  = {a1, a0};
    assign m_wdata = {d1, d0};

    always #5 i_clk = ~i_clk;

    bus_arbiter #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .LOCK_MAX(LM)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .read_addr(read_addr), .read_data(read_data),
        .write_addr(write_addr), .write_data(write_data), .write_strobe(write_strobe)
    );

    // Slave: 256-word RAM with one cycle of read latency.
    logic [DW-1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge i_clk) begin
        if (write_strobe) mem[write_addr[7:0]] <= write_data;
        read_data <= mem[read_addr[7:0]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] shadow [256];
    int            cyc = 0;
    int            last_m, owner, owned, cand, mm;
    logic [AW-1:0] hold_ra, hold_wa, caddr;
    logic [DW-1:0] hold_wd, cdata, erd;
    logic [N-1:0]  eg, erv;
    logic          es;

    initial for (int i = 0; i < 256; i++) shadow[i] = '0;

    always @(negedge i_clk) begin
        if (i_reset) begin
            check("rst_gnt", 32'(m_gnt), 32'h0);
            check("rst_rvalid", 32'(m_rvalid), 32'h0);
            check("rst_strobe", 32'(write_strobe), 32'h0);
            last_m = N - 1; owner = -1; owned = 0;
            rq.delete();
            hold_ra = '0; hold_wa = '0; hold_wd = '0;
        end else begin
            cand = -1;
            if (owner >= 0) begin
                if (m_req[owner]) cand = owner;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    mm = (last_m + k) % N;
                    if (cand < 0 && m_req[mm]) cand = mm;
                end
            end
            eg = '0; es = 1'b0; erv = '0; erd = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv[rq[0].id] = 1'b1;
                erd = rq[0].data;
                void'(rq.pop_front());
            end
            if (cand >= 0) begin
                eg[cand] = 1'b1;
                caddr = m_addr[cand*AW +: AW];
                cdata = m_wdata[cand*DW +: DW];
                if (m_we[cand]) begin
                    es = 1'b1; hold_wa = caddr; hold_wd = cdata;
                    shadow[caddr[7:0]] = cdata;
                end else begin
                    hold_ra = caddr;
                    rq.push_back('{due: cyc + RL, id: cand, data: shadow[caddr[7:0]]});
                end
                last_m = cand;
            end
            check("gnt", 32'(m_gnt), 32'(eg));
            check("strobe", 32'(write_strobe), 32'(es));
            check("write_addr", 32'(write_addr), 32'(hold_wa));
            check("write_data", 32'(write_data), 32'(hold_wd));
            check("read_addr", 32'(read_addr), 32'(hold_ra));
            check("rvalid", 32'(m_rvalid), 32'(erv));
            if (erv != '0) check("rdata", 32'(m_rdata), 32'(erd));
            if (owner >= 0) begin
                owned++;
                if (owned == LM || !m_lock[owner]) begin
                    owner = -1; owned = 0;
                end
            end else if (cand >= 0 && m_lock[cand]) begin
                owner = cand; owned = 0;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"}, 32'(m_gnt), 32'h0);
        check({tag, "_rvalid"}, 32'(m_rvalid), 32'h0);
        check({tag, "_strobe"}, 32'(write_strobe), 32'h0);
        check({tag, "_raddr"}, 32'(read_addr), 32'h0);
        check({tag, "_waddr"}, 32'(write_addr), 32'h0);
        check({tag, "_wdata"}, 32'(write_data), 32'h0);
    endtask

    logic [N-1:0] t2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [DW-1:0] t2d [4] = '{16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    logic [N-1:0] t3 [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [N-1:0] t4 [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    initial begin
        i_reset = 1'b1; m_req = '0; m_we = '0; m_lock = '0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk); check_reset_values("reset");
        step();

        // Single master: write then read back.
        m_req = 2'b01; m_we = 2'b01; a0 = 16'h0040; d0 = 16'h1234;
        @(negedge i_clk);
        check("t1_wgnt", 32'(m_gnt), 32'h1);
        check("t1_strobe", 32'(write_strobe), 32'h1);
        check("t1_waddr", 32'(write_addr), 32'h0040);
        check("t1_wdata", 32'(write_data), 32'h1234);
        step();
        m_we = 2'b00;
        @(negedge i_clk);
        check("t1_rgnt", 32'(m_gnt), 32'h1);
        check("t1_raddr", 32'(read_addr), 32'h0040);
        check("t1_rstrobe", 32'(write_strobe), 32'h0);
        step();
        m_req = 2'b00;
        @(negedge i_clk);
        check("t1_rvalid", 32'(m_rvalid), 32'h1);
        check("t1_rdata", 32'(m_rdata), 32'h1234);
        check("t1_hold_waddr", 32'(write_addr), 32'h0040);
        step();
        m_req = 2'b10; m_we = 2'b10; a1 = 16'h0041; d1 = 16'hBEEF;
        step();
        m_req = 2'b00; i_reset = 1'b1;
        step();
        i_reset = 1'b0;

        // Contention: both masters read continuously for four cycles.
        m_req = 2'b11; m_we = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check("t2_gnt", 32'(m_gnt), 32'(t2[k]));
            if (k > 0) begin
                check("t2_rvalid", 32'(m_rvalid), 32'(t2[k-1]));
                check("t2_rdata", 32'(m_rdata), 32'(t2d[k-1]));
            end
            step();
        end
        m_req = 2'b00;
        @(negedge i_clk);
        check("t2_rvalid_last", 32'(m_rvalid), 32'(t2[3]));
        check("t2_rdata_last", 32'(m_rdata), 32'(t2d[3]));
        step();

        // Lock: master 1 does three locked writes and one unlocked write.
        m_we = 2'b11; a0 = 16'h0050; d0 = 16'h5555; a1 = 16'h0060;
        for (int k = 0; k < 6; k++) begin
            m_req  = {k < 5 ? 1'b1 : 1'b0, 1'b1};
            m_lock = {k < 4 ? 1'b1 : 1'b0, 1'b0};
            d1 = 16'hA000 + 16'(k);
            @(negedge i_clk);
            check("t3_gnt", 32'(m_gnt), 32'(t3[k]));
            step();
        end

        // Lock timeout: master 1 never releases.
        m_req = 2'b11; m_lock = 2'b10;
        for (int k = 0; k < 7; k++) begin
            @(negedge i_clk);
            check("t4_gnt", 32'(m_gnt), 32'(t4[k]));
            step();
        end
        m_req = 2'b00; m_lock = 2'b00;
        step();

        // Reset while a read is in flight.
        m_req = 2'b01; m_we = 2'b00; a0 = 16'h0040;
        @(negedge i_clk);
        check("t5_rgnt", 32'(m_gnt), 32'h1);
        step();
        i_reset = 1'b1; m_req = 2'b00;
        @(negedge i_clk);
        check("t5_rvalid_dropped", 32'(m_rvalid), 32'h0);
        step();
        i_reset = 1'b0;
        @(negedge i_clk); check_reset_values("t5");
        step();
        m_req = 2'b11;
        @(negedge i_clk);
        check("t5_first_gnt", 32'(m_gnt), 32'h1);
        step();
        m_req = 2'b00;
        @(negedge i_clk);
        check("t5_rvalid", 32'(m_rvalid), 32'h1);
        check("t5_rdata", 32'(m_rdata), 32'h1234);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
